// File: rtl/cont_updown_modn.sv
// Up/down modulo-MODULUS counter with preset, clamped parallel load, wrap or saturate mode,
// boundary flags and a registered one-cycle terminal-count pulse on every wrap.
module cont_updown_modn #(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 10,
  parameter int PRESET_VAL = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Preset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             En,
  input  logic             Y,
  input  logic             Sat,
  output logic [WIDTH-1:0] Q,
  output logic             AtMax,
  output logic             AtMin,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PRESET_Q = WIDTH'(PRESET_VAL);

  if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
    $error("cont_updown_modn: WIDTH must be in 1..30");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("cont_updown_modn: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESET_VAL < 0 || PRESET_VAL >= MODULUS) begin : g_bad_preset
    $error("cont_updown_modn: PRESET_VAL must be in 0..MODULUS-1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  // Bounds are tested against MAX_VAL, so a full 2**WIDTH range still wraps
  // through the explicit compare rather than relying on arithmetic overflow.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (Preset) begin
      count_d = PRESET_Q;
    end else if (Load) begin
      count_d = (LoadVal > MAX_VAL) ? MAX_VAL : LoadVal;
    end else if (En) begin
      if (Y) begin
        if (count_q == MAX_VAL) begin
          if (!Sat) begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          if (!Sat) begin
            count_d = MAX_VAL;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign Q     = count_q;
  assign Tc    = tc_q;
  assign AtMax = (count_q == MAX_VAL);
  assign AtMin = (count_q == '0);

endmodule

// File: tb/tb_cont_updown_modn.sv
// Bench for cont_updown_modn: a default 4-bit mod-10 instance driven from a vector table,
// plus a 2-bit mod-4 instance exercising the full-range wrap; results checked via a scoreboard queue.
module tb_cont_updown_modn;

  logic       clk;
  logic       rst_n;
  logic       preset, load, en, y, sat;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       at_max, at_min, tc;

  logic       preset4, load4, en4, y4, sat4;
  logic [1:0] load_val4;
  logic [1:0] q4;
  logic       at_max4, at_min4, tc4;

  int n_pass  = 0;
  int n_total = 0;

  cont_updown_modn #(.WIDTH(4), .MODULUS(10), .PRESET_VAL(2)) dut (
    .Clk(clk), .Rst_n(rst_n), .Preset(preset), .Load(load), .LoadVal(load_val),
    .En(en), .Y(y), .Sat(sat), .Q(q), .AtMax(at_max), .AtMin(at_min), .Tc(tc)
  );

  cont_updown_modn #(.WIDTH(2), .MODULUS(4), .PRESET_VAL(1)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Preset(preset4), .Load(load4), .LoadVal(load_val4),
    .En(en4), .Y(y4), .Sat(sat4), .Q(q4), .AtMax(at_max4), .AtMin(at_min4), .Tc(tc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       preset;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       y;
    logic       sat;
    logic [3:0] exp_q;
    logic       exp_tc;
  } vec_t;

  typedef struct {
    bit         sel;
    string      name;
    logic [3:0] q;
    logic       tc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add_vec(input logic p, input logic l, input logic [3:0] lv,
                                  input logic e, input logic yy, input logic s,
                                  input logic [3:0] eq, input logic etc);
    vec_t v;
    v.preset = p; v.load = l; v.load_val = lv; v.en = e; v.y = yy; v.sat = s;
    v.exp_q = eq; v.exp_tc = etc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (!e.sel) begin
      check({e.name, ".q"},     32'(q),      32'(e.q));
      check({e.name, ".tc"},    32'(tc),     32'(e.tc));
      check({e.name, ".atmax"}, 32'(at_max), 32'(e.q == 4'd9));
      check({e.name, ".atmin"}, 32'(at_min), 32'(e.q == 4'd0));
    end else begin
      check({e.name, ".q4"},     32'(q4),      32'(e.q));
      check({e.name, ".tc4"},    32'(tc4),     32'(e.tc));
      check({e.name, ".atmax4"}, 32'(at_max4), 32'(e.q == 4'd3));
      check({e.name, ".atmin4"}, 32'(at_min4), 32'(e.q == 4'd0));
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input string name, input bit sel, input logic p, input logic l,
                      input logic [3:0] lv, input logic e, input logic yy, input logic s,
                      input logic [3:0] eq, input logic etc);
    exp_t x;
    @(negedge clk);
    if (!sel) begin
      preset = p; load = l; load_val = lv; en = e; y = yy; sat = s;
    end else begin
      preset4 = p; load4 = l; load_val4 = lv[1:0]; en4 = e; y4 = yy; sat4 = s;
    end
    x.sel = sel; x.name = name; x.q = eq; x.tc = etc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
    if (!sel) begin
      preset = 1'b0; load = 1'b0; en = 1'b0;
    end else begin
      preset4 = 1'b0; load4 = 1'b0; en4 = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".q"},      32'(q),       32'd0);
    check({name, ".tc"},     32'(tc),      32'd0);
    check({name, ".atmin"},  32'(at_min),  32'd1);
    check({name, ".atmax"},  32'(at_max),  32'd0);
    check({name, ".q4"},     32'(q4),      32'd0);
    check({name, ".atmin4"}, 32'(at_min4), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    preset = 0; load = 0; load_val = 0; en = 0; y = 1; sat = 0;
    preset4 = 0; load4 = 0; load_val4 = 0; en4 = 0; y4 = 1; sat4 = 0;

    // up wrap from 0 in wrap mode
    for (int i = 1; i <= 9; i++) add_vec(0, 0, 4'd0, 1, 1, 0, 4'(i), 0);
    add_vec(0, 0, 4'd0, 1, 1, 0, 4'd0, 1);
    add_vec(0, 0, 4'd0, 1, 1, 0, 4'd1, 0);
    // down saturate at 0
    add_vec(0, 0, 4'd0, 1, 0, 1, 4'd0, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 4'd0, 1, 0, 1, 4'd0, 0);
    // load clamp beats enable, up saturate at max, preset beats load
    add_vec(0, 1, 4'd13, 1, 1, 0, 4'd9, 0);
    add_vec(0, 0, 4'd0,  1, 1, 1, 4'd9, 0);
    add_vec(1, 1, 4'd4,  1, 1, 0, 4'd2, 0);
    // hold at 7 with enable low
    add_vec(0, 1, 4'd7, 0, 1, 0, 4'd7, 0);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 4'd0, 0, 0, 0, 4'd7, 0);
    // down wrap from 0, then pulse ends on hold
    add_vec(0, 1, 4'd0, 0, 0, 0, 4'd0, 0);
    add_vec(0, 0, 4'd0, 1, 0, 0, 4'd9, 1);
    add_vec(0, 0, 4'd0, 0, 0, 0, 4'd9, 0);
    // wrap pulse followed directly by a load
    add_vec(0, 0, 4'd0,  1, 1, 0, 4'd0, 1);
    add_vec(0, 1, 4'd5,  1, 0, 0, 4'd5, 0);
    add_vec(0, 1, 4'd15, 0, 0, 0, 4'd9, 0);
    add_vec(0, 1, 4'd10, 0, 0, 0, 4'd9, 0);

    #12;
    check_reset_state("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), 0, vecs[i].preset, vecs[i].load, vecs[i].load_val,
           vecs[i].en, vecs[i].y, vecs[i].sat, vecs[i].exp_q, vecs[i].exp_tc);

    // reset asserted mid-count, between edges
    step("rst_pre_load", 0, 0, 1, 4'd0, 0, 1, 0, 4'd0, 0);
    for (int i = 1; i <= 5; i++)
      step($sformatf("rst_up%0d", i), 0, 0, 0, 4'd0, 1, 1, 0, 4'(i), 0);
    step("dut4_pre", 1, 0, 1, 4'd2, 0, 1, 0, 4'd2, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_async");
    @(posedge clk);
    #1 check_reset_state("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_up", 0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0);

    // full-range 2-bit mod-4 instance
    step("m4_up1", 1, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0);
    step("m4_up2", 1, 0, 0, 4'd0, 1, 1, 0, 4'd2, 0);
    step("m4_up3", 1, 0, 0, 4'd0, 1, 1, 0, 4'd3, 0);
    step("m4_wrap", 1, 0, 0, 4'd0, 1, 1, 0, 4'd0, 1);
    step("m4_up_after", 1, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0);
    step("m4_preset", 1, 1, 1, 4'd3, 1, 1, 0, 4'd1, 0);
    step("m4_load0", 1, 0, 1, 4'd0, 0, 1, 0, 4'd0, 0);
    step("m4_down_wrap", 1, 0, 0, 4'd0, 1, 0, 0, 4'd3, 1);
    step("m4_up_sat", 1, 0, 0, 4'd0, 1, 1, 1, 4'd3, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
